// File: rtl/gray_codec_unit.sv
// rtl/gray_codec_unit.sv - registered Gray encode/decode channels and Gray pointer counter
//
// Purpose:
//   Gray-code helper for async-FIFO style clock-domain crossings.
//   The unit has three independent registered paths in one clock domain:
//     - encode channel : binary -> Gray, 1-cycle latency
//     - decode channel : Gray -> binary, 1-cycle latency
//     - pointer counter: binary count and Gray count registered together
//   The exported Gray pointer only ever changes one bit per increment,
//   including at wrap-around, so it is safe to synchronize into another domain.
//
// Ports:
//   clk_i        in   1      clock, all state updates on the rising edge
//   rst_ni       in   1      asynchronous active-low reset, clears all state
//   enc_valid_i  in   1      encode request strobe
//   enc_bin_i    in   WIDTH  binary value to encode
//   enc_valid_o  out  1      encode result valid (one cycle per request)
//   enc_gray_o   out  WIDTH  registered Gray result, holds when idle
//   dec_valid_i  in   1      decode request strobe
//   dec_gray_i   in   WIDTH  Gray value to decode
//   dec_valid_o  out  1      decode result valid (one cycle per request)
//   dec_bin_o    out  WIDTH  registered binary result, holds when idle
//   cnt_clr_i    in   1      synchronous counter clear (wins over cnt_en_i)
//   cnt_en_i     in   1      counter increment
//   cnt_bin_o    out  WIDTH  registered binary count
//   cnt_gray_o   out  WIDTH  registered Gray count, always Gray(cnt_bin_o)

module gray_codec_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enc_valid_i,
  input  logic [WIDTH-1:0] enc_bin_i,
  output logic             enc_valid_o,
  output logic [WIDTH-1:0] enc_gray_o,
  input  logic             dec_valid_i,
  input  logic [WIDTH-1:0] dec_gray_i,
  output logic             dec_valid_o,
  output logic [WIDTH-1:0] dec_bin_o,
  input  logic             cnt_clr_i,
  input  logic             cnt_en_i,
  output logic [WIDTH-1:0] cnt_bin_o,
  output logic [WIDTH-1:0] cnt_gray_o
);

  // Binary -> Gray: each Gray bit is the XOR of neighbouring binary bits,
  // the MSB passes straight through.
  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray -> binary: running XOR from the MSB downwards. Each binary bit
  // depends on the already-decoded bit above it, so the loop order matters.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b            = '0;
    b[WIDTH-1]   = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic             enc_valid_q, enc_valid_d;
  logic [WIDTH-1:0] enc_gray_q,  enc_gray_d;
  logic             dec_valid_q, dec_valid_d;
  logic [WIDTH-1:0] dec_bin_q,   dec_bin_d;
  logic [WIDTH-1:0] cnt_bin_q,   cnt_bin_d;
  logic [WIDTH-1:0] cnt_gray_q,  cnt_gray_d;

  // Incremented count, shared by the binary and Gray next-state so both
  // registers move on the same edge with no re-encode skew cycle.
  logic [WIDTH-1:0] cnt_bin_inc;

  // ---------------------------------------------------------------------------
  // Encode channel
  // ---------------------------------------------------------------------------
  always_comb begin
    enc_valid_d = enc_valid_i;
    enc_gray_d  = enc_gray_q;
    if (enc_valid_i) begin
      enc_gray_d = bin2gray(enc_bin_i);
    end
  end

  // ---------------------------------------------------------------------------
  // Decode channel
  // ---------------------------------------------------------------------------
  always_comb begin
    dec_valid_d = dec_valid_i;
    dec_bin_d   = dec_bin_q;
    if (dec_valid_i) begin
      dec_bin_d = gray2bin(dec_gray_i);
    end
  end

  // ---------------------------------------------------------------------------
  // Pointer counter: clear beats increment beats hold
  // ---------------------------------------------------------------------------
  assign cnt_bin_inc = cnt_bin_q + WIDTH'(1);

  always_comb begin
    cnt_bin_d  = cnt_bin_q;
    cnt_gray_d = cnt_gray_q;
    if (cnt_clr_i) begin
      cnt_bin_d  = '0;
      cnt_gray_d = '0;
    end else if (cnt_en_i) begin
      cnt_bin_d  = cnt_bin_inc;
      cnt_gray_d = bin2gray(cnt_bin_inc);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      enc_valid_q <= 1'b0;
      enc_gray_q  <= '0;
      dec_valid_q <= 1'b0;
      dec_bin_q   <= '0;
      cnt_bin_q   <= '0;
      cnt_gray_q  <= '0;
    end else begin
      enc_valid_q <= enc_valid_d;
      enc_gray_q  <= enc_gray_d;
      dec_valid_q <= dec_valid_d;
      dec_bin_q   <= dec_bin_d;
      cnt_bin_q   <= cnt_bin_d;
      cnt_gray_q  <= cnt_gray_d;
    end
  end

  // All outputs come straight from flops.
  assign enc_valid_o = enc_valid_q;
  assign enc_gray_o  = enc_gray_q;
  assign dec_valid_o = dec_valid_q;
  assign dec_bin_o   = dec_bin_q;
  assign cnt_bin_o   = cnt_bin_q;
  assign cnt_gray_o  = cnt_gray_q;

endmodule

// File: tb/tb_gray_codec_unit.sv
// tb/tb_gray_codec_unit.sv - randomized self-checking bench for gray_codec_unit

module tb_gray_codec_unit;

  localparam int W = 4;
  localparam int M = 1 << W;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         enc_valid_i = 1'b0;
  logic [W-1:0] enc_bin_i = '0;
  logic         enc_valid_o;
  logic [W-1:0] enc_gray_o;
  logic         dec_valid_i = 1'b0;
  logic [W-1:0] dec_gray_i = '0;
  logic         dec_valid_o;
  logic [W-1:0] dec_bin_o;
  logic         cnt_clr_i = 1'b0;
  logic         cnt_en_i = 1'b0;
  logic [W-1:0] cnt_bin_o;
  logic [W-1:0] cnt_gray_o;

  gray_codec_unit #(.WIDTH(W)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .enc_valid_i (enc_valid_i),
    .enc_bin_i   (enc_bin_i),
    .enc_valid_o (enc_valid_o),
    .enc_gray_o  (enc_gray_o),
    .dec_valid_i (dec_valid_i),
    .dec_gray_i  (dec_gray_i),
    .dec_valid_o (dec_valid_o),
    .dec_bin_o   (dec_bin_o),
    .cnt_clr_i   (cnt_clr_i),
    .cnt_en_i    (cnt_en_i),
    .cnt_bin_o   (cnt_bin_o),
    .cnt_gray_o  (cnt_gray_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference Gray code: reflected binary code by arithmetic.
  function automatic int ref_gray(input int b);
    return (b ^ (b >> 1)) % M;
  endfunction

  // Reference decode: find the unique value whose Gray code matches.
  function automatic int ref_bin(input int g);
    for (int v = 0; v < M; v++) if (ref_gray(v) == g) return v;
    return -1;
  endfunction

  // Advance one clock; inputs are then changed and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_enc_valid"}, 32'(enc_valid_o), 0);
    check({tag, "_enc_gray"},  32'(enc_gray_o),  0);
    check({tag, "_dec_valid"}, 32'(dec_valid_o), 0);
    check({tag, "_dec_bin"},   32'(dec_bin_o),   0);
    check({tag, "_cnt_bin"},   32'(cnt_bin_o),   0);
    check({tag, "_cnt_gray"},  32'(cnt_gray_o),  0);
  endtask

  int dir_bin  [5] = '{0, 1, 5, 8, 15};
  int dir_gray [5] = '{0, 1, 7, 12, 8};

  int cnt_m;
  int prev_gray;
  int exp_enc_gray, exp_dec_bin;
  int exp_enc_valid, exp_dec_valid;

  initial begin
    // Reset held low with inputs toggling.
    for (int i = 0; i < 4; i++) begin
      enc_valid_i = 1'b1; enc_bin_i = W'($urandom);
      dec_valid_i = 1'b1; dec_gray_i = W'($urandom);
      cnt_en_i = 1'b1; cnt_clr_i = 1'b0;
      step();
    end
    check_all_zero("reset_held");
    enc_valid_i = 1'b0; dec_valid_i = 1'b0; cnt_en_i = 1'b0;
    rst_ni = 1'b1;

    // Directed encode.
    for (int i = 0; i < 5; i++) begin
      enc_valid_i = 1'b1; enc_bin_i = W'(dir_bin[i]);
      step();
      check("enc_dir_gray",  32'(enc_gray_o),  32'(dir_gray[i]));
      check("enc_dir_valid", 32'(enc_valid_o), 1);
    end
    enc_valid_i = 1'b0; enc_bin_i = W'(3);
    step();
    check("enc_idle_valid", 32'(enc_valid_o), 0);
    check("enc_idle_hold",  32'(enc_gray_o),  8);

    // Directed decode.
    for (int i = 0; i < 5; i++) begin
      dec_valid_i = 1'b1; dec_gray_i = W'(dir_gray[i]);
      step();
      check("dec_dir_bin",   32'(dec_bin_o),   32'(dir_bin[i]));
      check("dec_dir_valid", 32'(dec_valid_o), 1);
    end
    dec_valid_i = 1'b0;
    step();
    check("dec_idle_valid", 32'(dec_valid_o), 0);
    check("dec_idle_hold",  32'(dec_bin_o),   15);

    // Exhaustive round trip, back-to-back: encode result of cycle k-1 is decoded in cycle k.
    for (int k = 0; k <= M; k++) begin
      enc_valid_i = (k < M);
      enc_bin_i   = W'(k % M);
      dec_valid_i = (k > 0);
      dec_gray_i  = enc_gray_o;
      step();
      if (k < M) check("rt_enc", 32'(enc_gray_o), 32'(ref_gray(k)));
      if (k > 0) begin
        check("rt_dec", 32'(dec_bin_o), 32'(k - 1));
        check("rt_dec_valid", 32'(dec_valid_o), 1);
      end
    end
    enc_valid_i = 1'b0; dec_valid_i = 1'b0;

    // Counter walk from reset across the wrap.
    rst_ni = 1'b0; #2; rst_ni = 1'b1;
    check("cnt_after_reset", 32'(cnt_bin_o), 0);
    cnt_m = 0; prev_gray = 0;
    cnt_en_i = 1'b1;
    for (int i = 0; i < 17; i++) begin
      step();
      cnt_m = (cnt_m + 1) % M;
      check("walk_bin",  32'(cnt_bin_o),  32'(cnt_m));
      check("walk_gray", 32'(cnt_gray_o), 32'(ref_gray(cnt_m)));
      check("walk_onebit", 32'($countones(cnt_gray_o ^ W'(prev_gray))), 1);
      prev_gray = int'(cnt_gray_o);
    end

    // Advance to 9, then clear and enable together.
    while (cnt_m != 9) begin
      step();
      cnt_m = (cnt_m + 1) % M;
    end
    check("at_nine", 32'(cnt_bin_o), 9);
    cnt_clr_i = 1'b1;
    step();
    check("clr_bin",  32'(cnt_bin_o),  0);
    check("clr_gray", 32'(cnt_gray_o), 0);
    cnt_clr_i = 1'b0;
    step(); step(); step();
    cnt_en_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_bin",  32'(cnt_bin_o),  3);
      check("hold_gray", 32'(cnt_gray_o), 32'(ref_gray(3)));
    end

    // Async reset mid-count at 6, observed between clock edges.
    cnt_en_i = 1'b1;
    step(); step(); step();
    check("pre_async_bin", 32'(cnt_bin_o), 6);
    cnt_en_i = 1'b0;
    enc_valid_i = 1'b1; enc_bin_i = W'(5);
    dec_valid_i = 1'b1; dec_gray_i = W'(7);
    step();
    #2;
    rst_ni = 1'b0;
    #1;
    check_all_zero("async_reset");
    enc_valid_i = 1'b0; dec_valid_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();

    // Concurrent randomized traffic on all three paths.
    cnt_m = 0; prev_gray = 0;
    exp_enc_gray = 0; exp_dec_bin = 0; exp_enc_valid = 0; exp_dec_valid = 0;
    for (int i = 0; i < 300; i++) begin
      enc_valid_i = 1'($urandom_range(0, 3) != 0);
      enc_bin_i   = W'($urandom);
      dec_valid_i = 1'($urandom_range(0, 3) != 0);
      dec_gray_i  = W'($urandom);
      cnt_clr_i   = 1'($urandom_range(0, 19) == 0);
      cnt_en_i    = 1'($urandom_range(0, 2) != 0);
      if (enc_valid_i) exp_enc_gray = ref_gray(int'(enc_bin_i));
      exp_enc_valid = int'(enc_valid_i);
      if (dec_valid_i) exp_dec_bin = ref_bin(int'(dec_gray_i));
      exp_dec_valid = int'(dec_valid_i);
      if (cnt_clr_i) cnt_m = 0;
      else if (cnt_en_i) cnt_m = (cnt_m + 1) % M;
      step();
      check("rnd_enc_valid", 32'(enc_valid_o), 32'(exp_enc_valid));
      check("rnd_enc_gray",  32'(enc_gray_o),  32'(exp_enc_gray));
      check("rnd_dec_valid", 32'(dec_valid_o), 32'(exp_dec_valid));
      check("rnd_dec_bin",   32'(dec_bin_o),   32'(exp_dec_bin));
      check("rnd_cnt_bin",   32'(cnt_bin_o),   32'(cnt_m));
      check("rnd_cnt_gray",  32'(cnt_gray_o),  32'(ref_gray(cnt_m)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
